game_state_ctrl: RTL

//  Top-level game flow FSM: TITLE -> START -> PLAY <-> PAUSE -> OVER -> START.

---
 rtl/game_pkg.sv | 15 +
 rtl/game_state_ctrl_rise_edge.sv | 24 ++
 rtl/game_state_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-flow types and constants, used by the game state controller
// and the health tracker.
package game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_START = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [2:0] HEALTH_INIT = 3'd5;

endpackage

// File: rtl/game_state_ctrl_rise_edge.sv
// Registered rising-edge detector: one-Clk pulse, one Clk after d rises.
// RESET_VAL=1 suppresses a press from a level held high through Reset.
module rise_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            d_q   <= RESET_VAL;
            pulse <= 1'b0;
        end else begin
            d_q   <= d;
            pulse <= d & ~d_q;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow FSM (TITLE -> START -> PLAY <-> PAUSE -> OVER -> START) with
// survival-seconds counter, high score and registered health HUD.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC   = 60,
    parameter int OVER_HOLD_FRAMES = 180,
    parameter int MAX_SECONDS      = 999,
    parameter int SEC_W            = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             start_key,
    input  logic             pause_key,
    input  logic             game_over,
    input  logic [2:0]       health_in,
    output logic [2:0]       state_out,
    output logic             play_en,
    output logic             game_reset,
    output logic [SEC_W-1:0] seconds,
    output logic [SEC_W-1:0] high_score,
    output logic [2:0]       health_hud
);

    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int HC_W = $clog2(OVER_HOLD_FRAMES + 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(OVER_HOLD_FRAMES);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SECONDS);

    logic            frame_tick;
    logic            start_press;
    logic            pause_press;
    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [FC_W-1:0] frame_cnt;
    logic [HC_W-1:0] hold_cnt;

    rise_edge #(.RESET_VAL(1'b0)) u_frame_edge (
        .Clk(Clk), .Reset(Reset), .d(frame_clk), .pulse(frame_tick)
    );
    rise_edge #(.RESET_VAL(1'b1)) u_start_edge (
        .Clk(Clk), .Reset(Reset), .d(start_key), .pulse(start_press)
    );
    rise_edge #(.RESET_VAL(1'b1)) u_pause_edge (
        .Clk(Clk), .Reset(Reset), .d(pause_key), .pulse(pause_press)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_TITLE;
        else       state <= state_nxt;
    end

    // game_over is deliberately not looked at in START: it may be stale.
    always_comb begin
        state_nxt = ST_TITLE;
        case (state)
            ST_TITLE: state_nxt = start_press ? ST_START : ST_TITLE;
            ST_START: state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (game_over)        state_nxt = ST_OVER;
                else if (pause_press) state_nxt = ST_PAUSE;
                else                  state_nxt = ST_PLAY;
            end
            ST_PAUSE: begin
                if (game_over)        state_nxt = ST_OVER;
                else if (pause_press) state_nxt = ST_PLAY;
                else                  state_nxt = ST_PAUSE;
            end
            ST_OVER: state_nxt = (hold_cnt == HOLD_MAX && start_press) ? ST_START : ST_OVER;
            default: state_nxt = ST_TITLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            seconds    <= '0;
            high_score <= '0;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                ST_START: begin
                    seconds   <= '0;
                    frame_cnt <= '0;
                end
                ST_PLAY, ST_PAUSE: begin
                    if (game_over) begin
                        if (seconds > high_score) high_score <= seconds;
                        hold_cnt <= '0;
                    end else if (state == ST_PLAY && !pause_press && frame_tick) begin
                        if (frame_cnt == FC_LAST) begin
                            frame_cnt <= '0;
                            if (seconds != SEC_MAX) seconds <= seconds + SEC_W'(1);
                        end else begin
                            frame_cnt <= frame_cnt + FC_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (frame_tick && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HC_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) health_hud <= HEALTH_INIT;
        else       health_hud <= health_in;
    end

    assign state_out  = state;
    assign play_en    = (state == ST_PLAY);
    assign game_reset = (state == ST_START);

endmodule
